// File: rtl/decode_stage.sv
// Two-entry (output + skid) RV32 ALU decode stage with registered outputs.
// DECODE_STAGE_ILLEGAL_CHECK_EN enables illegal-instruction detection.
module decode_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        inst_valid,
    input  logic [31:0] inst,
    output logic        inst_ready,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic        opImm,
    output logic [4:0]  rs1Addr,
    output logic [4:0]  rs2Addr,
    output logic [4:0]  rdAddr,
    output logic [31:0] immediateI,
    output logic        aluOp,
    output logic        illegal
);

    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef struct packed {
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        opImm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        aluOp;
        logic        illegal;
    } dec_t;

    dec_t w_dec;
    dec_t r_out;
    dec_t r_skid;
    logic r_out_v;
    logic r_skid_v;
    logic r_rdy;

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_is_op;
    logic       w_is_opimm;
    logic       w_acc;
    logic       w_take;

    assign w_opc      = inst[6:0];
    assign w_f3       = inst[14:12];
    assign w_f7       = inst[31:25];
    assign w_is_op    = (w_opc == OPC_OP);
    assign w_is_opimm = (w_opc == OPC_OPIMM);

    always_comb begin
        w_dec         = '0;
        w_dec.funct3  = w_f3;
        w_dec.funct7  = w_f7;
        w_dec.rd      = inst[11:7];
        w_dec.rs1     = inst[19:15];
        w_dec.rs2     = inst[24:20];
        w_dec.imm     = {{20{inst[31]}}, inst[31:20]};
        w_dec.opImm   = w_is_opimm;
`ifdef DECODE_STAGE_ILLEGAL_CHECK_EN
        w_dec.illegal = !(w_is_op || w_is_opimm)
            || (w_is_op && w_f7 != F7_ZERO && w_f7 != F7_ALT)
            || (w_is_op && w_f7 == F7_ALT
                && w_f3 != 3'b000 && w_f3 != 3'b101)
            || (w_is_opimm && w_f3 == 3'b001 && w_f7 != F7_ZERO)
            || (w_is_opimm && w_f3 == 3'b101
                && w_f7 != F7_ZERO && w_f7 != F7_ALT);
        w_dec.aluOp   = (w_is_op || w_is_opimm) && !w_dec.illegal;
`else
        w_dec.illegal = 1'b0;
        w_dec.aluOp   = w_is_op || w_is_opimm;
`endif
    end

    assign w_acc  = inst_valid && r_rdy;
    assign w_take = !r_out_v || dec_ready;

    // skid entry always has priority over a new beat so order is kept
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_out    <= '0;
            r_skid   <= '0;
            r_out_v  <= 1'b0;
            r_skid_v <= 1'b0;
            r_rdy    <= 1'b1;
        end else if (flush) begin
            r_out_v  <= 1'b0;
            r_skid_v <= 1'b0;
            r_rdy    <= 1'b1;
        end else if (w_take) begin
            if (r_skid_v) begin
                r_out    <= r_skid;
                r_out_v  <= 1'b1;
                r_skid_v <= 1'b0;
                r_rdy    <= 1'b1;
            end else if (w_acc) begin
                r_out   <= w_dec;
                r_out_v <= 1'b1;
            end else begin
                r_out_v <= 1'b0;
            end
        end else if (w_acc) begin
            r_skid   <= w_dec;
            r_skid_v <= 1'b1;
            r_rdy    <= 1'b0;
        end
    end

    assign inst_ready = r_rdy;
    assign dec_valid  = r_out_v;
    assign funct3     = r_out.funct3;
    assign funct7     = r_out.funct7;
    assign opImm      = r_out.opImm;
    assign rs1Addr    = r_out.rs1;
    assign rs2Addr    = r_out.rs2;
    assign rdAddr     = r_out.rd;
    assign immediateI = r_out.imm;
    assign aluOp      = r_out.aluOp;
    assign illegal    = r_out.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed + scoreboard bench for decode_stage.
// Honours DECODE_STAGE_ILLEGAL_CHECK_EN for expected illegal/aluOp values.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_ready;
    logic        dec_valid;
    logic        dec_ready;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        opImm;
    logic [4:0]  rs1Addr;
    logic [4:0]  rs2Addr;
    logic [4:0]  rdAddr;
    logic [31:0] immediateI;
    logic        aluOp;
    logic        illegal;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        oi;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        alu;
        logic        ill;
    } exp_t;

    logic [31:0] sb[$];
    logic        p_stall = 1'b0;
    exp_t        p_snap;

`ifdef DECODE_STAGE_ILLEGAL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    decode_stage dut (
        .clock(clock), .reset(reset), .flush(flush),
        .inst_valid(inst_valid), .inst(inst),
        .inst_ready(inst_ready), .dec_valid(dec_valid),
        .dec_ready(dec_ready), .funct3(funct3), .funct7(funct7),
        .opImm(opImm), .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
        .rdAddr(rdAddr), .immediateI(immediateI),
        .aluOp(aluOp), .illegal(illegal)
    );

    always #5 clock = ~clock;

    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        logic legal;
        e.f3  = w[14:12];
        e.f7  = w[31:25];
        e.rd  = w[11:7];
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.imm = {{20{w[31]}}, w[31:20]};
        e.oi  = 1'b0;
        legal = 1'b0;
        case (w[6:0])
            7'h13: begin
                e.oi = 1'b1;
                case (w[14:12])
                    3'd1:    legal = (w[31:25] == 7'h00);
                    3'd5:    legal = (w[31:25] == 7'h00)
                                  || (w[31:25] == 7'h20);
                    default: legal = 1'b1;
                endcase
            end
            7'h33: begin
                if (w[31:25] == 7'h00)
                    legal = 1'b1;
                else if (w[31:25] == 7'h20)
                    legal = (w[14:12] == 3'd0)
                         || (w[14:12] == 3'd5);
            end
            default: legal = 1'b0;
        endcase
        if (CHK) begin
            e.ill = !legal;
            e.alu = legal;
        end else begin
            e.ill = 1'b0;
            e.alu = (w[6:0] == 7'h13) || (w[6:0] == 7'h33);
        end
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.f3 = funct3; o.f7 = funct7; o.oi = opImm;
        o.rs1 = rs1Addr; o.rs2 = rs2Addr; o.rd = rdAddr;
        o.imm = immediateI; o.alu = aluOp; o.ill = illegal;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // scoreboard, stall-stability and upstream capture
    always @(negedge clock) begin
        if (p_stall && dec_valid && reset)
            chk("stable", 64'(observed()), 64'(p_snap));
        if (dec_valid && dec_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 64'(dec_valid), 64'(0));
            end else begin
                chk("sb_out", 64'(observed()),
                    64'(model(sb.pop_front())));
            end
        end
        if (!reset || flush)
            sb.delete();
        else if (inst_valid && inst_ready)
            sb.push_back(inst);
        p_stall = dec_valid && !dec_ready && reset && !flush;
        p_snap  = observed();
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send1(input logic [31:0] w);
        inst       = w;
        inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
    endtask

    task automatic fill_ab_offer_c();
        dec_ready  = 1'b0;
        inst_valid = 1'b1;
        inst       = 32'h00100093;
        tick();
        inst       = 32'h00200113;
        tick();
        inst       = 32'h00300193;
        chk("fill_ready", 64'(inst_ready), 64'(0));
        chk("fill_valid", 64'(dec_valid), 64'(1));
    endtask

    initial begin
        reset      = 1'b0;
        flush      = 1'b0;
        dec_ready  = 1'b1;
        inst_valid = 1'b1;
        inst       = 32'h00500093;
        tick();
        chk("rst_ready", 64'(inst_ready), 64'(1));
        chk("rst_valid", 64'(dec_valid), 64'(0));
        chk("rst_outs", 64'(observed()), 64'(0));
        tick();
        chk("rst_noacc", 64'(dec_valid), 64'(0));
        reset      = 1'b1;
        inst_valid = 1'b0;
        tick();
        chk("post_rst_valid", 64'(dec_valid), 64'(0));

        send1(32'h00500093);
        chk("addi_valid", 64'(dec_valid), 64'(1));
        chk("addi_opimm", 64'(opImm), 64'(1));
        chk("addi_aluop", 64'(aluOp), 64'(1));
        chk("addi_f3", 64'(funct3), 64'(0));
        chk("addi_rd", 64'(rdAddr), 64'(1));
        chk("addi_rs1", 64'(rs1Addr), 64'(0));
        chk("addi_imm", 64'(immediateI), 64'h5);

        send1(32'h40208133);
        chk("sub_f7", 64'(funct7), 64'h20);
        chk("sub_f3", 64'(funct3), 64'(0));
        chk("sub_opimm", 64'(opImm), 64'(0));
        chk("sub_rs1", 64'(rs1Addr), 64'(1));
        chk("sub_rs2", 64'(rs2Addr), 64'(2));
        chk("sub_rd", 64'(rdAddr), 64'(2));
        chk("sub_ill", 64'(illegal), 64'(0));

        send1(32'h4010D093);
        chk("srai_f3", 64'(funct3), 64'(5));
        chk("srai_f7", 64'(funct7), 64'h20);
        chk("srai_imm", 64'(immediateI), 64'h401);

        send1(32'hFFF00093);
        chk("neg_imm", 64'(immediateI), 64'hFFFFFFFF);

        send1(32'h0000006F);
        chk("jal_aluop", 64'(aluOp), 64'(0));
        chk("jal_ill", 64'(illegal), 64'(CHK));

        send1(32'h40109093);
        chk("slli_ill", 64'(illegal), 64'(CHK));
        chk("slli_aluop", 64'(aluOp), 64'(!CHK));
        tick();
        chk("drained", 64'(dec_valid), 64'(0));

        // random burst with random backpressure
        for (int i = 0; i < 40; i++) begin
            logic [31:0] w;
            int tries;
            bit acc;
            w = $urandom;
            case ($urandom_range(0, 3))
                0: w[6:0] = 7'h13;
                1: w[6:0] = 7'h33;
                2: begin w[6:0] = 7'h33; w[31:25] = 7'h20; end
                default: ;
            endcase
            inst       = w;
            inst_valid = 1'b1;
            tries      = 0;
            do begin
                dec_ready = 1'($urandom);
                acc = inst_ready;
                tick();
                tries++;
            end while (!acc && tries < 50);
            if (!acc)
                chk("burst_timeout", 64'(acc), 64'(1));
        end
        inst_valid = 1'b0;
        dec_ready  = 1'b1;
        repeat (4) tick();
        chk("burst_empty", 64'(sb.size()), 64'(0));
        chk("burst_idle", 64'(dec_valid), 64'(0));

        // A, B, C under backpressure, then release
        fill_ab_offer_c();
        chk("a_held", 64'(rdAddr), 64'(1));
        tick();
        chk("c_blocked", 64'(inst_ready), 64'(0));
        chk("a_still", 64'(rdAddr), 64'(1));
        dec_ready = 1'b1;
        tick();
        chk("b_out", 64'(rdAddr), 64'(2));
        chk("b_ready_back", 64'(inst_ready), 64'(1));
        tick();
        chk("c_out", 64'(rdAddr), 64'(3));
        chk("c_valid", 64'(dec_valid), 64'(1));
        inst_valid = 1'b0;
        tick();
        chk("abc_done", 64'(dec_valid), 64'(0));
        chk("abc_empty", 64'(sb.size()), 64'(0));

        // flush with both entries full
        fill_ab_offer_c();
        flush = 1'b1;
        tick();
        flush      = 1'b0;
        inst_valid = 1'b0;
        chk("flush_valid", 64'(dec_valid), 64'(0));
        chk("flush_ready", 64'(inst_ready), 64'(1));
        dec_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("flush_quiet", 64'(dec_valid), 64'(0));
        end

        // flush beats a simultaneous accept
        inst       = 32'h00700393;
        inst_valid = 1'b1;
        flush      = 1'b1;
        tick();
        flush      = 1'b0;
        inst_valid = 1'b0;
        chk("flush_wins", 64'(dec_valid), 64'(0));
        tick();
        chk("flush_wins2", 64'(dec_valid), 64'(0));

        // reset with both entries full
        fill_ab_offer_c();
        reset = 1'b0;
        tick();
        chk("mrst_valid", 64'(dec_valid), 64'(0));
        chk("mrst_ready", 64'(inst_ready), 64'(1));
        chk("mrst_outs", 64'(observed()), 64'(0));
        reset      = 1'b1;
        inst_valid = 1'b0;
        dec_ready  = 1'b1;
        repeat (3) begin
            tick();
            chk("mrst_quiet", 64'(dec_valid), 64'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
